// File: rtl/id_ex_pipeline_reg.sv
// ---------------------------------------------------------------------------
// id_ex_pipeline_reg
// Decode-to-execute pipeline register for the RV32I 5-stage core.
//
// Captures the D-stage control bundle, operands, immediate, PC/PC+4 and
// register indices on each rising edge of clk and presents them as E-stage
// signals. Update priority per edge: rst > FlushE > StallE > load.
//
// Ports:
//   clk, rst            core clock (rising edge), async active-high reset
//   StallE              hold every E-stage field this cycle
//   FlushE              load a bubble (all zero, ValidE=0); beats StallE
//   ValidD              D stage holds a real instruction
//   *D                  decode controls, operands, indices (sampled at edge)
//   *E                  registered E-stage copies
//   BubbleCountE        saturating count of bubbles entering E (optional)
//   StallCountE         saturating count of stalled cycles (optional)
//
// Optional feature macro: ID_EX_PERF_CNT_EN
//   defined   : BubbleCountE / StallCountE are saturating counters
//   undefined : both ports are tied to 0 and no counter flops exist
// ---------------------------------------------------------------------------
module id_ex_pipeline_reg #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      StallE,
    input  logic                      FlushE,
    input  logic                      ValidD,
    input  logic                      RegWriteD,
    input  logic                      MemWriteD,
    input  logic                      JumpD,
    input  logic                      BranchD,
    input  logic                      ALUSrcD,
    input  logic                      JALRInstrD,
    input  logic [1:0]                ResultSrcD,
    input  logic [3:0]                ALUControlD,
    input  logic [2:0]                AddressingControlD,
    input  logic [DATA_WIDTH-1:0]     RD1D,
    input  logic [DATA_WIDTH-1:0]     RD2D,
    input  logic [DATA_WIDTH-1:0]     ImmExtD,
    input  logic [DATA_WIDTH-1:0]     PCD,
    input  logic [DATA_WIDTH-1:0]     PCPlus4D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
    input  logic [REG_ADDR_WIDTH-1:0] RdD,
    output logic                      ValidE,
    output logic                      RegWriteE,
    output logic                      MemWriteE,
    output logic                      JumpE,
    output logic                      BranchE,
    output logic                      ALUSrcE,
    output logic                      JALRInstrE,
    output logic [1:0]                ResultSrcE,
    output logic [3:0]                ALUControlE,
    output logic [2:0]                AddressingControlE,
    output logic [DATA_WIDTH-1:0]     RD1E,
    output logic [DATA_WIDTH-1:0]     RD2E,
    output logic [DATA_WIDTH-1:0]     ImmExtE,
    output logic [DATA_WIDTH-1:0]     PCE,
    output logic [DATA_WIDTH-1:0]     PCPlus4E,
    output logic [REG_ADDR_WIDTH-1:0] Rs1E,
    output logic [REG_ADDR_WIDTH-1:0] Rs2E,
    output logic [REG_ADDR_WIDTH-1:0] RdE,
    output logic [CNT_WIDTH-1:0]      BubbleCountE,
    output logic [CNT_WIDTH-1:0]      StallCountE
);

    logic                      r_valid;
    logic                      r_reg_write;
    logic                      r_mem_write;
    logic                      r_jump;
    logic                      r_branch;
    logic                      r_alu_src;
    logic                      r_jalr;
    logic [1:0]                r_result_src;
    logic [3:0]                r_alu_control;
    logic [2:0]                r_addr_control;
    logic [DATA_WIDTH-1:0]     r_rd1;
    logic [DATA_WIDTH-1:0]     r_rd2;
    logic [DATA_WIDTH-1:0]     r_imm;
    logic [DATA_WIDTH-1:0]     r_pc;
    logic [DATA_WIDTH-1:0]     r_pc_plus4;
    logic [REG_ADDR_WIDTH-1:0] r_rs1;
    logic [REG_ADDR_WIDTH-1:0] r_rs2;
    logic [REG_ADDR_WIDTH-1:0] r_rd;

    // A write to x0 is architecturally a no-op; dropping it here keeps the
    // forwarding unit from matching Rd==0 against a live source.
    logic w_rd_nonzero;
    logic w_reg_write_d;

    assign w_rd_nonzero  = |RdD;
    assign w_reg_write_d = RegWriteD & ValidD & w_rd_nonzero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid        <= 1'b0;
            r_reg_write    <= 1'b0;
            r_mem_write    <= 1'b0;
            r_jump         <= 1'b0;
            r_branch       <= 1'b0;
            r_alu_src      <= 1'b0;
            r_jalr         <= 1'b0;
            r_result_src   <= '0;
            r_alu_control  <= '0;
            r_addr_control <= '0;
            r_rd1          <= '0;
            r_rd2          <= '0;
            r_imm          <= '0;
            r_pc           <= '0;
            r_pc_plus4     <= '0;
            r_rs1          <= '0;
            r_rs2          <= '0;
            r_rd           <= '0;
        end else if (FlushE) begin
            // Bubble = addi x0,x0,0 marked invalid; D bus is not looked at,
            // so unknown D values during a flush cannot leak into E.
            r_valid        <= 1'b0;
            r_reg_write    <= 1'b0;
            r_mem_write    <= 1'b0;
            r_jump         <= 1'b0;
            r_branch       <= 1'b0;
            r_alu_src      <= 1'b0;
            r_jalr         <= 1'b0;
            r_result_src   <= '0;
            r_alu_control  <= '0;
            r_addr_control <= '0;
            r_rd1          <= '0;
            r_rd2          <= '0;
            r_imm          <= '0;
            r_pc           <= '0;
            r_pc_plus4     <= '0;
            r_rs1          <= '0;
            r_rs2          <= '0;
            r_rd           <= '0;
        end else if (!StallE) begin
            r_valid        <= ValidD;
            // Architectural side effects only for real instructions.
            r_reg_write    <= w_reg_write_d;
            r_mem_write    <= MemWriteD & ValidD;
            r_jump         <= JumpD & ValidD;
            r_branch       <= BranchD & ValidD;
            r_jalr         <= JALRInstrD & ValidD;
            // Mux selects and datapath fields are harmless when invalid.
            r_alu_src      <= ALUSrcD;
            r_result_src   <= ResultSrcD;
            r_alu_control  <= ALUControlD;
            r_addr_control <= AddressingControlD;
            r_rd1          <= RD1D;
            r_rd2          <= RD2D;
            r_imm          <= ImmExtD;
            r_pc           <= PCD;
            r_pc_plus4     <= PCPlus4D;
            r_rs1          <= Rs1D;
            r_rs2          <= Rs2D;
            r_rd           <= RdD;
        end
    end

    assign ValidE             = r_valid;
    assign RegWriteE          = r_reg_write;
    assign MemWriteE          = r_mem_write;
    assign JumpE              = r_jump;
    assign BranchE            = r_branch;
    assign ALUSrcE            = r_alu_src;
    assign JALRInstrE         = r_jalr;
    assign ResultSrcE         = r_result_src;
    assign ALUControlE        = r_alu_control;
    assign AddressingControlE = r_addr_control;
    assign RD1E               = r_rd1;
    assign RD2E               = r_rd2;
    assign ImmExtE            = r_imm;
    assign PCE                = r_pc;
    assign PCPlus4E           = r_pc_plus4;
    assign Rs1E               = r_rs1;
    assign Rs2E               = r_rs2;
    assign RdE                = r_rd;

`ifdef ID_EX_PERF_CNT_EN
    localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] r_bubble_cnt;
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic                 w_bubble_evt;
    logic                 w_stall_evt;

    // A bubble enters E on a flush, or on a load of an invalid D slot.
    assign w_bubble_evt = FlushE | (~StallE & ~ValidD);
    assign w_stall_evt  = StallE & ~FlushE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bubble_cnt <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (w_bubble_evt && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + CntOne;
            end
            if (w_stall_evt && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CntOne;
            end
        end
    end

    assign BubbleCountE = r_bubble_cnt;
    assign StallCountE  = r_stall_cnt;
`else
    assign BubbleCountE = '0;
    assign StallCountE  = '0;
`endif

endmodule

// File: doc/id_ex_pipeline_reg.md
Name: id_ex_pipeline_reg

Overview:
- Decode-to-execute pipeline register for the RV32I 5-stage core.
- Sits directly downstream of the decode control unit and register file.
- Captures D-stage control bundle, operands, immediate, PC and register addresses each cycle; presents them as E-stage signals.
- Implements stall (hold), flush (bubble insert) and x0-write suppression, so forwarding and hazard logic see clean E-stage controls.

Parameters:
- DATA_WIDTH, 32, width of operands, immediate and PC fields
- REG_ADDR_WIDTH, 5, register-index width
- CNT_WIDTH, 32, width of optional performance counters

Ports:
- clk  in  1  core clock, rising-edge
- rst  in  1  asynchronous active-high reset
- StallE  in  1  hold all E-stage state this cycle
- FlushE  in  1  replace captured instruction with bubble
- ValidD  in  1  D-stage holds a real instruction
- RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, JALRInstrD  in  1 each  decode controls
- ResultSrcD  in  2  writeback mux select
- ALUControlD  in  4  ALU operation
- AddressingControlD  in  3  load/store width/sign (funct3)
- RD1D, RD2D, ImmExtD, PCD, PCPlus4D  in  DATA_WIDTH each  operands, immediate, PC, PC+4
- Rs1D, Rs2D, RdD  in  REG_ADDR_WIDTH each  source/dest indices
- ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, JALRInstrE  out  1 each  registered controls
- ResultSrcE  out  2; ALUControlE  out  4; AddressingControlE  out  3
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  DATA_WIDTH each
- Rs1E, Rs2E, RdE  out  REG_ADDR_WIDTH each
- BubbleCountE, StallCountE  out  CNT_WIDTH each  performance counters (optional feature)

Behaviour:
- Reset is asynchronous and active-high on rst; single clock domain clk. Assertion immediately zeroes every output; deassertion takes effect at the next rising edge. rst mid-stall or mid-flush discards all state.
- Per-edge update priority: rst > FlushE > StallE > load.
- Load (no flush, no stall): every E field takes its D value one cycle later (latency 1).
  - ValidE <= ValidD.
  - Architectural controls gated by ValidD: RegWriteE, MemWriteE, JumpE, BranchE, JALRInstrE <= D value AND ValidD.
  - RegWriteE is additionally forced 0 when RdD == 0.
  - Data, index and non-architectural fields (ResultSrc, ALUControl, ALUSrc, AddressingControl) load unconditionally.
- FlushE=1: all outputs except counters load 0 (bubble = addi x0,x0,0 with ValidE=0). Independent of StallE and ValidD.
- StallE=1, FlushE=0: all outputs hold their current value, including ValidE.
- FlushE and StallE together: flush wins; bubble inserted.
- No combinational path from any input to any output.
- All D-bus inputs are sampled only at the edge; X on D inputs while FlushE=1 must not propagate.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN
- Defined:
  - BubbleCountE increments on each edge where FlushE=1, or where a load occurs with ValidD=0.
  - StallCountE increments on each edge where StallE=1 and FlushE=0.
  - Both counters saturate at all-ones and reset to 0 on rst.
- Undefined: both ports remain and are tied to constant 0; no counter flops are synthesised.

Test Plan:
- Reset: assert rst with all D inputs 1s → every output 0 immediately, before any clock edge. Release rst, drive add x5,x1,x2 (RegWriteD=1, ALUControlD=0000, RdD=5, RD1D=0x10, RD2D=0x20, ValidD=1) → next edge: RegWriteE=1, RdE=5, RD1E=0x10, RD2E=0x20, ValidE=1.
- x0 suppression: addi x0,x0,7 with RegWriteD=1, RdD=0, ImmExtD=7 → RegWriteE=0, ImmExtE=7, ValidE=1.
- Stall: load sw (MemWriteD=1, AddressingControlD=010, PCD=0x40). Assert StallE for 3 cycles while D inputs change to beq (PCD=0x44) → MemWriteE=1 and PCE=0x40 held for all 3 cycles. Deassert StallE → PCE=0x44, BranchE=1, ALUControlE=0001.
- Flush vs stall: StallE=1 and FlushE=1 on the same edge with jal in D (JumpD=1, ResultSrcD=10) → all E outputs 0, ValidE=0. With the macro defined: BubbleCountE +1, StallCountE unchanged.
- Invalid D: ValidD=0 with RegWriteD=1, MemWriteD=1, RD1D=0xDEAD → RegWriteE=0, MemWriteE=0, ValidE=0, RD1E=0xDEAD.
- Counter saturation (macro defined, CNT_WIDTH=4): 20 consecutive stall cycles → StallCountE stays at 0xF. Assert rst → 0.
